part_4_seq_subtractor: RTL and testbench
========================================

PART_4_SEQ_SUBTRACTOR -- requirements
Module: part_4_seq_subtractor

Interface
REQ-001 The block SHALL have parameter HALF, default 16, giving the half-word width; W = 2*HALF is the operand width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port a, input, W bits: minuend.
REQ-005 The block SHALL have port b, input, W bits: subtrahend.
REQ-006 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have port diff, output, W bits: result a - b - bin, modulo 2^W.
REQ-010 The block SHALL have port bout, output, 1 bit: borrow-out of the high half, i.e. unsigned a < b + bin.
REQ-011 The block SHALL have port ovf, output, 1 bit: signed (two's-complement) overflow.
REQ-012 The block SHALL have port out_valid, output, 1 bit: diff, bout and ovf are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOW, HIGH and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-016 In IDLE with in_valid=1 at an edge, the block SHALL capture a, b and bin into internal registers and go to LOW.
REQ-017 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-018 In LOW, the block SHALL compute {borrow_mid, lo} = a[HALF-1:0] - b[HALF-1:0] - bin, store lo and borrow_mid, then go to HIGH.
  - Only the captured copies of a, b and bin are used.
  - borrow_mid is 1 when the low-half result is negative.
REQ-019 In HIGH, the block SHALL compute {borrow_hi, hi} = a[W-1:HALF] - b[W-1:HALF] - borrow_mid.
  - diff <= {hi, lo}; bout <= borrow_hi.
  - ovf <= (a[W-1] != b[W-1]) && (hi[HALF-1] != a[W-1]).
  - Next state is DONE.
REQ-020 out_valid SHALL be 1 exactly while the state is DONE.
  - Latency: out_valid rises 3 clock edges after the accepting edge.
REQ-021 In DONE with out_ready=1, the block SHALL go to IDLE.
REQ-022 In DONE with out_ready=0, the block SHALL hold diff, bout, ovf and out_valid stable, with no limit on wait time.
REQ-023 Input ports a, b, bin and in_valid SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.
REQ-024 The minimum initiation interval SHALL be 4 cycles.
  - Back-to-back: if out_ready=1 on entering DONE, IDLE follows one cycle later and accepts a new operand set.
REQ-025 diff, bout and ovf SHALL keep the last result after leaving DONE, until the next HIGH state overwrites them.
REQ-026 Arithmetic SHALL wrap modulo 2^W with no saturation; a=0, b=0, bin=1 gives all-ones with bout=1.

Reset
REQ-027 With rst=1 at an edge, the block SHALL force:
  - state = IDLE;
  - diff = 0, bout = 0, ovf = 0, out_valid = 0;
  - in_ready = 1 after the edge;
  - all internal operand and borrow registers = 0.
REQ-028 rst SHALL take priority over every other input; an assertion in LOW, HIGH or DONE SHALL discard the operation in progress, with no partial result visible.
REQ-029 An operand set with in_valid=1 in the same cycle as rst=1 SHALL NOT be accepted.

Verification (HALF=16)
REQ-030 a=0x0001_0000, b=0x0000_0001, bin=0 -> diff=0x0000_FFFF, bout=0, ovf=0; out_valid rises 3 edges after accept (tests cross-half borrow).
REQ-031 a=0, b=1, bin=0 -> diff=0xFFFF_FFFF, bout=1, ovf=0; and a=5, b=5, bin=1 -> diff=0xFFFF_FFFF, bout=1, ovf=0.
REQ-032 a=0x8000_0000, b=1 -> diff=0x7FFF_FFFF, bout=0, ovf=1; and a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, bout=1, ovf=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands ->
  - outputs stay stable and in_ready stays 0;
  - the new operands are not taken;
  - after out_ready=1, IDLE is reached and the next operand set is accepted.
REQ-034 Assert rst for 1 cycle while in HIGH -> on the next cycle out_valid=0, in_ready=1, diff=0, bout=0, ovf=0, and no result is produced for the aborted operation.
REQ-035 Streaming: issue 3 operand sets with out_ready tied to 1 -> results arrive in order, one every 4 cycles, and each matches a reference model.

Source files
------------

// File: rtl/part_4_seq_subtractor.sv
// -----------------------------------------------------------------------------
// part_4_seq_subtractor
//
// Multi-cycle W-bit subtractor (W = 2*HALF) that computes a - b - bin
// one half-word at a time. It uses a valid/ready handshake on both sides.
//
// Sequence: IDLE captures the operands. LOW subtracts the low halves. HIGH
// subtracts the high halves and registers the result. DONE presents the
// result until the consumer takes it.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   a, b       : W-bit minuend and subtrahend
//   bin        : borrow-in
//   in_valid   : operand set on a/b/bin is valid
//   in_ready   : block is idle and will take an operand set
//   diff       : a - b - bin, modulo 2^W
//   bout       : borrow-out, i.e. unsigned a < b + bin
//   ovf        : two's-complement overflow of the subtraction
//   out_valid  : diff/bout/ovf hold a fresh result
//   out_ready  : consumer accepts the result
// -----------------------------------------------------------------------------
module part_4_seq_subtractor #(
    parameter int HALF = 16,
    localparam int W = 2 * HALF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    // Captured operands, so that the input ports are free to change mid-operation.
    logic [W-1:0]    a_q, b_q;
    logic            bin_q;
    logic [HALF-1:0] lo;
    logic            borrow_mid;

    // Each half-subtraction is one bit wider than a half-word. The top bit
    // becomes 1 when the true result is negative, so that bit is the borrow.
    logic [HALF:0] low_sub, high_sub;

    assign low_sub  = {1'b0, a_q[HALF-1:0]} - {1'b0, b_q[HALF-1:0]}
                    - {{HALF{1'b0}}, bin_q};
    assign high_sub = {1'b0, a_q[W-1:HALF]} - {1'b0, b_q[W-1:HALF]}
                    - {{HALF{1'b0}}, borrow_mid};

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every signal gets a default first; a path that leaves one
        // unassigned would infer a latch.
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = LOW;
            end
            LOW:  next_state = HIGH;
            HIGH: next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers. The result registers are written only in HIGH.
    // They therefore hold steady through DONE backpressure and after the
    // result has been taken.
    always_ff @(posedge clk) begin
        // NOTE: these are plain flops rather than a memory array. Resetting
        // them is cheap, and it guarantees that no stale or partial result
        // survives an abort.
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            bin_q      <= 1'b0;
            lo         <= '0;
            borrow_mid <= 1'b0;
            diff       <= '0;
            bout       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        bin_q <= bin;
                    end
                end
                LOW: begin
                    lo         <= low_sub[HALF-1:0];
                    borrow_mid <= low_sub[HALF];
                end
                HIGH: begin
                    diff <= {high_sub[HALF-1:0], lo};
                    bout <= high_sub[HALF];
                    // Overflow is only possible when the operand signs differ.
                    // It occurs when the result sign departs from the minuend sign.
                    ovf  <= (a_q[W-1] != b_q[W-1]) && (high_sub[HALF-1] != a_q[W-1]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_part_4_seq_subtractor.sv
// -----------------------------------------------------------------------------
// tb_part_4_seq_subtractor
//
// Directed bench for part_4_seq_subtractor with HALF=16. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge. Expected values
// are hand-computed constants, plus a one-line full-width reference for the
// streaming vectors.
// -----------------------------------------------------------------------------
module tb_part_4_seq_subtractor;

    localparam int HALF = 16;
    localparam int W    = 2 * HALF;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    part_4_seq_subtractor #(.HALF(HALF)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full-width reference: {bout, ovf, diff}
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0] full;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        return {full[W], (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]), full[W-1:0]};
    endfunction

    // Presents one operand set in IDLE and lets the accepting edge pass.
    // It then scrambles the ports, which the block must ignore. Next it waits,
    // with a bound, for out_valid and checks the latency and the result.
    // out_ready is left at 0, so the result is still in DONE on return.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] e_diff, input logic e_bout,
                          input logic e_ovf);
        int n;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = x; b = y; bin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~x; b = ~y; bin = ~c;
        n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        // The accepting edge is the first of three; out_valid appears after the third.
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_diff"}, 64'(diff), 64'(e_diff));
        check({tag, "_bout"}, 64'(bout), 64'(e_bout));
        check({tag, "_ovf"},  64'(ovf),  64'(e_ovf));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] held_diff;
        logic [W+1:0] exp_r;
        logic [W-1:0] sa [3];
        logic [W-1:0] sb [3];
        logic         sc [3];
        int           t_prev;
        int           n;

        rst = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff",      64'(diff),      64'd0);
        check("rst_bout",      64'(bout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);

        // Borrow crosses from the low half into the high half.
        run_op("cross", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
        release_result("cross");
        check("cross_retained", 64'(diff), 64'h0000_FFFF);

        // Wrap-around and borrow-in.
        run_op("wrap",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        release_result("wrap");
        run_op("binw",  32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        release_result("binw");
        run_op("zero1", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        release_result("zero1");

        // Signed overflow in both directions.
        run_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        release_result("ovf_neg");
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        release_result("ovf_pos");

        // Backpressure: DONE is held while new operands are offered.
        run_op("bp", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h0246_8ACE, 1'b0, 1'b0);
        a = 32'h0000_0009; b = 32'h0000_0002; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_diff",      64'(diff),      64'h0246_8ACE);
        end
        in_valid = 1'b0;
        release_result("bp");
        check("bp_no_take", 64'(out_valid), 64'd0);
        run_op("bp_next", 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
        release_result("bp_next");

        // Reset while in HIGH aborts the operation.
        a = 32'h0005_0000; b = 32'h0001_0001; bin = 1'b0; in_valid = 1'b1;
        tick();                     // accepted, now in LOW
        in_valid = 1'b0;
        tick();                     // now in HIGH
        check("abort_in_high", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_diff",      64'(diff),      64'd0);
        check("abort_bout",      64'(bout),      64'd0);
        check("abort_ovf",       64'(ovf),       64'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("abort_no_result", 64'(n), 64'd0);

        // in_valid during reset is not accepted.
        rst = 1'b1; in_valid = 1'b1; a = 32'h0000_0003; b = 32'h0000_0001;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_iv_in_ready", 64'(in_ready), 64'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("rst_iv_no_result", 64'(n), 64'd0);

        // Streaming with out_ready held high: one result every 4 cycles.
        sa[0] = 32'hFFFF_0000; sb[0] = 32'h0000_FFFF; sc[0] = 1'b1;
        sa[1] = 32'h0000_0000; sb[1] = 32'h8000_0000; sc[1] = 1'b0;
        sa[2] = 32'hDEAD_BEEF; sb[2] = 32'hDEAD_BEEF; sc[2] = 1'b0;
        out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            check("st_in_ready", 64'(in_ready), 64'd1);
            a = sa[k]; b = sb[k]; bin = sc[k]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 8) begin
                tick();
                n++;
            end
            check("st_latency", 64'(n), 64'd2);
            exp_r = ref_sub(sa[k], sb[k], sc[k]);
            check("st_diff", 64'(diff), 64'(exp_r[W-1:0]));
            check("st_bout", 64'(bout), 64'(exp_r[W+1]));
            check("st_ovf",  64'(ovf),  64'(exp_r[W]));
            if (k > 0) check("st_interval", 64'(cyc - t_prev), 64'd4);
            t_prev = cyc;
            held_diff = diff;
            tick();
            check("st_out_valid_drop", 64'(out_valid), 64'd0);
            check("st_keep", 64'(diff), 64'(held_diff));
        end
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
